// File: rtl/soc_system_sysid_regs_pkg.sv
// soc_system_sysid_pkg
// Shared constants for the system-ID register block: word addresses, CTRL/STAT
// bit positions, CAPS field positions and a helper that packs the CAPS word.
package soc_system_sysid_pkg;

  localparam logic [3:0] ADDR_ID        = 4'd0;
  localparam logic [3:0] ADDR_TIMESTAMP = 4'd1;
  localparam logic [3:0] ADDR_CAPS      = 4'd2;
  localparam logic [3:0] ADDR_CTRL      = 4'd3;
  localparam logic [3:0] ADDR_UPTIME_LO = 4'd4;
  localparam logic [3:0] ADDR_UPTIME_HI = 4'd5;
  localparam logic [3:0] ADDR_SCRATCH0  = 4'd8;

  localparam int CTRL_CNT_EN = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_OVF    = 8;

  localparam int CAPS_VER_LSB  = 16;
  localparam int CAPS_NSCR_LSB = 8;
  localparam int CAPS_LAT_LSB  = 0;

  function automatic logic [31:0] caps_word(input logic [15:0] ver, input int nscr, input int lat);
    logic [31:0] w;
    w = '0;
    w[CAPS_VER_LSB  +: 16] = ver;
    w[CAPS_NSCR_LSB +: 8]  = nscr[7:0];
    w[CAPS_LAT_LSB  +: 8]  = lat[7:0];
    return w;
  endfunction

endpackage

// File: rtl/soc_system_sysid_regs_if.sv
// soc_system_sysid_regs_if
// Avalon-MM slave bus for the system-ID block (no waitrequest; reads return
// through readdatavalid).
//   address[3:0]   word address
//   read / write   one-cycle strobes
//   writedata      write data, byteenable selects lanes
//   readdata       read data, qualified by readdatavalid
interface soc_system_sysid_regs_if;
  logic [3:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;
  logic        readdatavalid;

  modport slave  (input  address, read, write, writedata, byteenable,
                  output readdata, readdatavalid);
  modport master (output address, read, write, writedata, byteenable,
                  input  readdata, readdatavalid);
endinterface

// File: rtl/soc_system_sysid_regs_rdpipe.sv
// soc_system_sysid_rdpipe
// LATENCY-deep read-return pipeline. Valid and data move together; a
// synchronous reset drops everything in flight.
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_vld, i_data     read accepted this cycle / data sampled this cycle
//   o_vld, o_data     readdatavalid / readdata, LATENCY cycles later
module soc_system_sysid_rdpipe #(
  parameter int LATENCY = 1,
  parameter int W       = 32
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_vld,
  input  logic [W-1:0] i_data,
  output logic         o_vld,
  output logic [W-1:0] o_data
);

  logic [LATENCY:1]         r_vld_pipe;
  logic [LATENCY:1][W-1:0]  r_dat_pipe;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_vld_pipe <= '0;
      r_dat_pipe <= '0;
    end else begin
      r_vld_pipe[1] <= i_vld;
      r_dat_pipe[1] <= i_data;
      for (int s = 2; s <= LATENCY; s++) begin
        r_vld_pipe[s] <= r_vld_pipe[s-1];
        r_dat_pipe[s] <= r_dat_pipe[s-1];
      end
    end
  end

  assign o_vld  = r_vld_pipe[LATENCY];
  assign o_data = r_dat_pipe[LATENCY];

endmodule

// File: rtl/soc_system_sysid_regs.sv
// soc_system_sysid_regs
// System-ID / info register block on the lightweight HPS bridge.
//   clock, reset   system clock, synchronous active-high reset
//   bus (slave)    Avalon-MM register port, see soc_system_sysid_regs_if
//   overflow_irq   level interrupt: sticky uptime overflow AND irq_en
// Map: 0 ID, 1 TIMESTAMP, 2 CAPS, 3 CTRL/STAT, 4 UPTIME_LO, 5 UPTIME_HI,
//      8.. scratch. Everything else reads 0 and ignores writes.
module soc_system_sysid_regs
  import soc_system_sysid_pkg::*;
#(
  parameter logic [31:0] ID_VALUE     = 32'hACD5_1302,
  parameter logic [31:0] TIMESTAMP    = 32'h5589_A35F,
  parameter logic [15:0] VERSION      = 16'h0002,
  parameter int          NUM_SCRATCH  = 2,
  parameter int          READ_LATENCY = 1,
  parameter int          CNT_W        = 64
) (
  input  logic                    clock,
  input  logic                    reset,
  soc_system_sysid_regs_if.slave  bus,
  output logic                    overflow_irq
);

  localparam logic [31:0] CAPS_VAL = caps_word(VERSION, NUM_SCRATCH, READ_LATENCY);

  logic [CNT_W-1:0]                   r_cnt;
  logic [31:0]                        r_hi_shadow;
  logic                               r_cnt_en;
  logic                               r_irq_en;
  logic                               r_ovf;
  logic [NUM_SCRATCH-1:0][31:0]       r_scratch;

  logic        w_wr;
  logic        w_wr_ctrl;
  logic        w_rd_lo;
  logic        w_wrap;
  logic [31:0] w_ctrl;
  logic [31:0] w_rdata;

  // A read in the same cycle as a write wins; the write is dropped.
  assign w_wr      = bus.write & ~bus.read;
  assign w_wr_ctrl = w_wr & (bus.address == ADDR_CTRL);
  assign w_rd_lo   = bus.read & (bus.address == ADDR_UPTIME_LO);
  assign w_wrap    = r_cnt_en & (&r_cnt);

  always_comb begin
    w_ctrl              = '0;
    w_ctrl[CTRL_CNT_EN] = r_cnt_en;
    w_ctrl[CTRL_IRQ_EN] = r_irq_en;
    w_ctrl[CTRL_OVF]    = r_ovf;
  end

  always_comb begin
    w_rdata = '0;
    case (bus.address)
      ADDR_ID:        w_rdata = ID_VALUE;
      ADDR_TIMESTAMP: w_rdata = TIMESTAMP;
      ADDR_CAPS:      w_rdata = CAPS_VAL;
      ADDR_CTRL:      w_rdata = w_ctrl;
      ADDR_UPTIME_LO: w_rdata = r_cnt[31:0];
      ADDR_UPTIME_HI: w_rdata = r_hi_shadow;
      default: begin
        for (int k = 0; k < NUM_SCRATCH; k++)
          if (bus.address == ADDR_SCRATCH0 + 4'(k)) w_rdata = r_scratch[k];
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt       <= '0;
      r_hi_shadow <= '0;
      r_cnt_en    <= 1'b1;
      r_irq_en    <= 1'b0;
      r_ovf       <= 1'b0;
      r_scratch   <= '0;
    end else begin
      if (r_cnt_en) r_cnt <= r_cnt + CNT_W'(1);

      // LO read freezes the upper half so a following HI read is tear-free.
      if (w_rd_lo) r_hi_shadow <= r_cnt[63:32];

      if (w_wr_ctrl && bus.byteenable[0]) begin
        r_cnt_en <= bus.writedata[CTRL_CNT_EN];
        r_irq_en <= bus.writedata[CTRL_IRQ_EN];
      end

      // A wrap on the same edge as a W1C keeps the flag set.
      if (w_wrap)
        r_ovf <= 1'b1;
      else if (w_wr_ctrl && bus.byteenable[1] && bus.writedata[CTRL_OVF])
        r_ovf <= 1'b0;

      for (int k = 0; k < NUM_SCRATCH; k++)
        if (w_wr && bus.address == ADDR_SCRATCH0 + 4'(k))
          for (int b = 0; b < 4; b++)
            if (bus.byteenable[b]) r_scratch[k][b*8 +: 8] <= bus.writedata[b*8 +: 8];
    end
  end

  assign overflow_irq = r_ovf & r_irq_en;

  soc_system_sysid_rdpipe #(
    .LATENCY (READ_LATENCY),
    .W       (32)
  ) u_rdpipe (
    .i_clk  (clock),
    .i_rst  (reset),
    .i_vld  (bus.read),
    .i_data (w_rdata),
    .o_vld  (bus.readdatavalid),
    .o_data (bus.readdata)
  );

endmodule

// File: tb/tb_soc_system_sysid_regs.sv
module tb_soc_system_sysid_regs;
  import soc_system_sysid_pkg::*;

  logic clk = 1'b0;
  logic rst1 = 1'b1;
  logic rst2 = 1'b1;
  logic irq1, irq2;

  always #5 clk = ~clk;

  soc_system_sysid_regs_if b1();
  soc_system_sysid_regs_if b2();

  soc_system_sysid_regs #(.READ_LATENCY(1)) dut1 (
    .clock(clk), .reset(rst1), .bus(b1), .overflow_irq(irq1));
  soc_system_sysid_regs #(.READ_LATENCY(2)) dut2 (
    .clock(clk), .reset(rst2), .bus(b2), .overflow_irq(irq2));

  typedef struct { logic [31:0] data; int due; } exp_t;
  exp_t q1[$];
  exp_t q2[$];
  exp_t e1, e2;

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  // Scoreboard monitors: pop and compare whenever readdatavalid is seen.
  always @(negedge clk) begin
    if (b1.readdatavalid) begin
      if (q1.size() == 0) chk("dut1 unexpected readdatavalid", 32'(b1.readdatavalid), 32'd0);
      else begin
        e1 = q1.pop_front();
        chk("dut1 readdata", b1.readdata, e1.data);
        chk("dut1 latency", cyc, e1.due);
      end
    end
  end

  always @(negedge clk) begin
    if (b2.readdatavalid) begin
      if (q2.size() == 0) chk("dut2 unexpected readdatavalid", 32'(b2.readdatavalid), 32'd0);
      else begin
        e2 = q2.pop_front();
        chk("dut2 readdata", b2.readdata, e2.data);
        chk("dut2 latency", cyc, e2.due);
      end
    end
  end

  task automatic rd1(input logic [3:0] a, input logic [31:0] e);
    b1.address = a; b1.read = 1'b1;
    q1.push_back('{e, cyc + 1});
    @(posedge clk); #1 b1.read = 1'b0;
  endtask

  task automatic wr1(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    b1.address = a; b1.writedata = d; b1.byteenable = be; b1.write = 1'b1;
    @(posedge clk); #1 b1.write = 1'b0;
  endtask

  task automatic rd2(input logic [3:0] a, input logic [31:0] e);
    b2.address = a; b2.read = 1'b1;
    q2.push_back('{e, cyc + 2});
    @(posedge clk); #1 b2.read = 1'b0;
  endtask

  task automatic wr2(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    b2.address = a; b2.writedata = d; b2.byteenable = be; b2.write = 1'b1;
    @(posedge clk); #1 b2.write = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    b1.address = '0; b1.read = 0; b1.write = 0; b1.writedata = '0; b1.byteenable = '0;
    b2.address = '0; b2.read = 0; b2.write = 0; b2.writedata = '0; b2.byteenable = '0;

    // ---- reset values and RO words, back-to-back reads
    repeat (3) @(posedge clk);
    #1;
    chk("rdv in reset", 32'(b1.readdatavalid), 32'd0);
    chk("readdata in reset", b1.readdata, 32'd0);
    rst1 = 1'b0;
    chk("irq after reset", 32'(irq1), 32'd0);
    rd1(ADDR_UPTIME_LO, 32'h0000_0000);
    rd1(ADDR_UPTIME_HI, 32'h0000_0000);
    rd1(ADDR_ID,        32'hACD5_1302);
    rd1(ADDR_TIMESTAMP, 32'h5589_A35F);
    rd1(ADDR_CAPS,      32'h0002_0201);
    rd1(ADDR_CTRL,      32'h0000_0001);
    rd1(4'd8,           32'h0000_0000);
    rd1(4'd9,           32'h0000_0000);
    rd1(4'd6,           32'h0000_0000);

    // ---- scratch byte enables, unmapped and RO writes
    wr1(4'd8, 32'hDEAD_BEEF, 4'b1111);
    wr1(4'd8, 32'h0000_1234, 4'b0011);
    rd1(4'd8, 32'hDEAD_1234);
    wr1(4'd9, 32'hA5A5_5A5A, 4'b1100);
    rd1(4'd9, 32'hA5A5_0000);
    wr1(4'd15, 32'hFFFF_FFFF, 4'b1111);
    rd1(4'd15, 32'h0000_0000);
    wr1(ADDR_ID, 32'h0000_0000, 4'b1111);
    rd1(ADDR_ID, 32'hACD5_1302);

    // ---- atomic LO/HI, HI stays put across the carry
    force dut1.r_cnt = 64'h0000_0000_FFFF_FFFE;
    #1 release dut1.r_cnt;
    rd1(ADDR_UPTIME_LO, 32'hFFFF_FFFE);
    rd1(ADDR_UPTIME_HI, 32'h0000_0000);
    rd1(ADDR_UPTIME_HI, 32'h0000_0000);
    rd1(ADDR_UPTIME_LO, 32'h0000_0001);
    rd1(ADDR_UPTIME_HI, 32'h0000_0001);
    // freeze: the write edge itself still counts (-> 4)
    wr1(ADDR_CTRL, 32'h0, 4'b0001);
    rd1(ADDR_UPTIME_LO, 32'h0000_0004);
    rd1(ADDR_UPTIME_LO, 32'h0000_0004);
    rd1(ADDR_UPTIME_HI, 32'h0000_0001);
    rd1(ADDR_CTRL, 32'h0000_0000);
    wr1(ADDR_CTRL, 32'h3, 4'b0001);
    rd1(ADDR_CTRL, 32'h0000_0003);
    rd1(ADDR_UPTIME_LO, 32'h0000_0005);

    // ---- wrap, sticky ovf, irq gating, W1C
    force dut1.r_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
    #1 release dut1.r_cnt;
    @(posedge clk); #1;
    chk("irq after wrap", 32'(irq1), 32'd1);
    rd1(ADDR_CTRL, 32'h0000_0103);
    wr1(ADDR_CTRL, 32'h1, 4'b0001);
    chk("irq masked", 32'(irq1), 32'd0);
    rd1(ADDR_CTRL, 32'h0000_0101);
    wr1(ADDR_CTRL, 32'h3, 4'b0001);
    chk("irq unmasked", 32'(irq1), 32'd1);
    wr1(ADDR_CTRL, 32'h100, 4'b0010);
    chk("irq after W1C", 32'(irq1), 32'd0);
    rd1(ADDR_CTRL, 32'h0000_0003);
    force dut1.r_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
    #1 release dut1.r_cnt;
    wr1(ADDR_CTRL, 32'h100, 4'b0010);
    chk("irq wrap beats W1C", 32'(irq1), 32'd1);
    rd1(ADDR_CTRL, 32'h0000_0103);
    wr1(ADDR_CTRL, 32'h103, 4'b0001);
    rd1(ADDR_CTRL, 32'h0000_0103);
    wr1(ADDR_CTRL, 32'h100, 4'b0010);
    rd1(ADDR_CTRL, 32'h0000_0003);

    // ---- read in the reset cycle never returns
    repeat (3) @(posedge clk);
    #1;
    b1.address = ADDR_ID; b1.read = 1'b1; rst1 = 1'b1;
    @(posedge clk); #1 b1.read = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("dut1 rdv flushed", 32'(b1.readdatavalid), 32'd0);
      chk("dut1 readdata reset", b1.readdata, 32'd0);
    end
    @(posedge clk); #1 rst1 = 1'b0;
    chk("irq reset", 32'(irq1), 32'd0);
    rd1(ADDR_UPTIME_HI, 32'h0000_0000);
    rd1(ADDR_UPTIME_LO, 32'h0000_0001);
    rd1(ADDR_CTRL,      32'h0000_0001);
    rd1(4'd8,           32'h0000_0000);

    // ---- latency-2 build
    repeat (2) @(posedge clk);
    #1 rst2 = 1'b0;
    rd2(ADDR_ID,        32'hACD5_1302);
    rd2(ADDR_TIMESTAMP, 32'h5589_A35F);
    rd2(ADDR_CAPS,      32'h0002_0202);
    wr2(4'd8, 32'h1122_3344, 4'b1111);
    b2.address = 4'd8; b2.writedata = 32'hCAFE_F00D; b2.byteenable = 4'b1111;
    b2.read = 1'b1; b2.write = 1'b1;
    q2.push_back('{32'h1122_3344, cyc + 2});
    @(posedge clk); #1 b2.read = 1'b0; b2.write = 1'b0;
    rd2(4'd8, 32'h1122_3344);
    b2.address = ADDR_CTRL; b2.writedata = 32'h0; b2.byteenable = 4'b1111;
    b2.read = 1'b1; b2.write = 1'b1;
    q2.push_back('{32'h0000_0001, cyc + 2});
    @(posedge clk); #1 b2.read = 1'b0; b2.write = 1'b0;
    rd2(ADDR_CTRL, 32'h0000_0001);

    // in-flight read killed by reset on the following cycle
    repeat (3) @(posedge clk);
    #1 b2.address = ADDR_ID; b2.read = 1'b1;
    @(posedge clk); #1 b2.read = 1'b0; rst2 = 1'b1;
    @(posedge clk); #1;
    repeat (4) begin
      @(negedge clk);
      chk("dut2 rdv flushed", 32'(b2.readdatavalid), 32'd0);
    end
    @(posedge clk); #1 rst2 = 1'b0;
    rd2(ADDR_CTRL, 32'h0000_0001);
    rd2(4'd8,      32'h0000_0000);

    for (int i = 0; i < 20 && (q1.size() != 0 || q2.size() != 0); i++) @(posedge clk);
    @(negedge clk);
    chk("scoreboard drained", 32'(q1.size() + q2.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
